// File: rtl/race_official_multi.sv
// Multi-lane race official: starts all enabled lanes together, reports the first finisher and aborts on timeout.
// Optional false-start detection is compiled in with `define FALSE_START_DET_EN.
module race_official_multi #(
  parameter  int LANES   = 4,
  parameter  int CNT_W   = 10,
  parameter  int TIMEOUT = 1000,
  localparam int IDX_W   = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LANES-1:0] lane_en,
  input  logic [LANES-1:0] ready,
  input  logic [LANES-1:0] done,
  output logic [LANES-1:0] start,
  output logic             race_active,
  output logic [IDX_W-1:0] winner,
  output logic             winner_valid,
  output logic [CNT_W-1:0] race_time,
  output logic             timeout,
  output logic             false_start
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RACE    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state, state_nx;
  logic [LANES-1:0] en_mask, en_mask_nx;
  logic [LANES-1:0] fin_mask, fin_mask_nx;
  logic [CNT_W-1:0] timer, timer_nx;
  logic [LANES-1:0] start_nx;
  logic [IDX_W-1:0] winner_nx;
  logic             winner_valid_nx;
  logic [CNT_W-1:0] race_time_nx;
  logic             timeout_nx;
  logic [LANES-1:0] fin_now;
  logic [LANES-1:0] fin_all;
  logic             ready_ok;
  logic             go;
  logic             to_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Scanning downwards leaves the lowest set index as the result.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [LANES-1:0] m);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (m[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  assign fin_now  = start & done & en_mask;
  assign fin_all  = fin_mask | fin_now;
  assign ready_ok = (lane_en != '0) && ((ready & lane_en) == lane_en);
  assign to_hit   = (TIMEOUT != 0) && (timer == TO_LAST);

`ifdef FALSE_START_DET_EN
  logic early_done;
  assign early_done = (done & lane_en) != '0;
  assign go         = ready_ok && !early_done;
`else
  assign go         = ready_ok;
`endif

  always_comb begin
    state_nx        = state;
    en_mask_nx      = en_mask;
    fin_mask_nx     = fin_mask;
    timer_nx        = timer;
    start_nx        = start;
    winner_nx       = winner;
    winner_valid_nx = winner_valid;
    race_time_nx    = race_time;
    timeout_nx      = timeout;
    case (state)
      IDLE: begin
        if (go) begin
          en_mask_nx      = lane_en;
          start_nx        = lane_en;
          fin_mask_nx     = '0;
          timer_nx        = '0;
          winner_valid_nx = 1'b0;
          timeout_nx      = 1'b0;
          state_nx        = RACE;
        end
      end
      RACE: begin
        timer_nx    = sat_inc(timer);
        start_nx    = start & ~fin_now;
        fin_mask_nx = fin_all;
        if (!winner_valid && (fin_now != '0)) begin
          winner_nx       = lowest_idx(fin_now);
          race_time_nx    = timer;
          winner_valid_nx = 1'b1;
        end
        // Finishes take priority: a race completed on the timeout cycle is not a timeout.
        if (fin_all == en_mask) begin
          state_nx = RELEASE;
        end else if (to_hit) begin
          timeout_nx = 1'b1;
          start_nx   = '0;
          state_nx   = RELEASE;
        end
      end
      RELEASE: begin
        if (((ready | done) & en_mask) == '0) state_nx = IDLE;
      end
      default: begin
        start_nx = '0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      en_mask      <= '0;
      fin_mask     <= '0;
      timer        <= '0;
      start        <= '0;
      winner       <= '0;
      winner_valid <= 1'b0;
      race_time    <= '0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_nx;
      en_mask      <= en_mask_nx;
      fin_mask     <= fin_mask_nx;
      timer        <= timer_nx;
      start        <= start_nx;
      winner       <= winner_nx;
      winner_valid <= winner_valid_nx;
      race_time    <= race_time_nx;
      timeout      <= timeout_nx;
    end
  end

  assign race_active = (state != IDLE);

`ifdef FALSE_START_DET_EN
  logic false_start_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) false_start_q <= 1'b0;
    else     false_start_q <= (state == IDLE) && early_done;
  end
  assign false_start = false_start_q;
`else
  assign false_start = 1'b0;
`endif

endmodule

// File: tb/tb_race_official_multi.sv
// Bench for race_official_multi: directed races plus randomized races checked against
// expectations derived from each lane's planned finish time.
module tb_race_official_multi;

  localparam int LANES   = 4;
  localparam int CNT_W   = 10;
  localparam int TIMEOUT = 20;
  localparam int IDX_W   = 2;

  logic             clk;
  logic             rst;
  logic [LANES-1:0] lane_en;
  logic [LANES-1:0] ready;
  logic [LANES-1:0] done;
  logic [LANES-1:0] start;
  logic             race_active;
  logic [IDX_W-1:0] winner;
  logic             winner_valid;
  logic [CNT_W-1:0] race_time;
  logic             timeout;
  logic             false_start;

  int vectors = 0;
  int errors  = 0;
  int prev_w  = 0;
  int prev_rt = 0;

  race_official_multi #(.LANES(LANES), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .lane_en(lane_en), .ready(ready), .done(done),
    .start(start), .race_active(race_active), .winner(winner),
    .winner_valid(winner_valid), .race_time(race_time), .timeout(timeout),
    .false_start(false_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    lane_en = '0; ready = '0; done = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    prev_w  = 0;
    prev_rt = 0;
  endtask

  // Plays one race in which enabled lane i raises done at timer f[i] and holds it.
  // A lane whose f[i] >= TIMEOUT never finishes within the race.
  task automatic run_race(input logic [3:0] en, input int f [4], input int hold);
    int end_t, min_f, exp_w;
    logic exp_to, exp_wv;
    logic [3:0] exp_start, dn;
    exp_to = 1'b0; min_f = TIMEOUT; end_t = 0; exp_w = prev_w;
    for (int i = 0; i < 4; i++) begin
      if (en[i]) begin
        if (f[i] < TIMEOUT) begin
          if (f[i] < min_f) begin min_f = f[i]; exp_w = i; end
          if (f[i] > end_t) end_t = f[i];
        end else begin
          exp_to = 1'b1;
        end
      end
    end
    if (exp_to) end_t = TIMEOUT - 1;
    exp_wv = (min_f < TIMEOUT);

    lane_en = en;
    ready   = en | (4'($urandom) & ~en);
    done    = '0;
    step();
    for (int t = 0; t <= end_t; t++) begin
      exp_start = '0;
      dn = '0;
      for (int i = 0; i < 4; i++) begin
        exp_start[i] = en[i] && (t <= f[i]) && (t < TIMEOUT);
        dn[i]        = en[i] && (t >= f[i]);
      end
      check("race_start", start, exp_start);
      check("race_active_run", race_active, 1'b1);
      lane_en = 4'($urandom);
      ready   = 4'($urandom);
      done    = dn | (4'($urandom) & ~en);
      step();
    end
    check("end_start", start, 4'h0);
    check("end_active", race_active, 1'b1);
    check("end_winner_valid", winner_valid, exp_wv);
    check("end_timeout", timeout, exp_to);
    check("end_winner", winner, exp_w);
    check("end_race_time", race_time, exp_wv ? min_f : prev_rt);
    for (int h = 0; h < hold; h++) begin
      lane_en = en; ready = en; done = '0;
      step();
      check("hold_active", race_active, 1'b1);
      check("hold_start", start, 4'h0);
    end
    lane_en = en; ready = '0; done = '0;
    step();
    check("idle_active", race_active, 1'b0);
    check("idle_winner_valid", winner_valid, exp_wv);
    check("idle_timeout", timeout, exp_to);
    check("idle_false_start", false_start, 1'b0);
    if (exp_wv) begin
      prev_w  = exp_w;
      prev_rt = min_f;
    end
  endtask

  initial begin
    int f [4];
    logic [3:0] en, part;
    rst = 1'b0; lane_en = '0; ready = '0; done = '0;
    #1 rst = 1'b1;
    #1;
    check("rst_start", start, 4'h0);
    check("rst_active", race_active, 1'b0);
    check("rst_winner", winner, 2'd0);
    check("rst_winner_valid", winner_valid, 1'b0);
    check("rst_race_time", race_time, 10'd0);
    check("rst_timeout", timeout, 1'b0);
    check("rst_false_start", false_start, 1'b0);
    do_reset();

    // T1: lane 2 first at timer 5
    f = '{8, 9, 5, 10};
    run_race(4'hF, f, 0);
    // T2: lanes 1 and 3 tie, lowest index wins
    f = '{6, 2, 4, 2};
    run_race(4'hF, f, 1);
    // T3: lane 0 never finishes
    f = '{100, 3, 3, 3};
    run_race(4'hF, f, 0);
    // T4: partial enable, ready held after finishing
    f = '{4, 0, 2, 0};
    run_race(4'b0101, f, 3);
    // Finishes on the timeout cycle complete the race without a timeout
    f = '{19, 7, 19, 1};
    run_race(4'hF, f, 0);

    // Incomplete ready never starts a race
    lane_en = 4'hF; ready = 4'hE; done = '0;
    step();
    check("partial_ready_active", race_active, 1'b0);
    check("partial_ready_start", start, 4'h0);

    for (int r = 0; r < 30; r++) begin
      en = 4'($urandom_range(1, 15));
      part = en & (en - 4'd1);
      lane_en = en; ready = part | (4'($urandom) & ~en); done = '0;
      step();
      check("rand_partial_active", race_active, 1'b0);
      for (int i = 0; i < 4; i++) f[i] = $urandom_range(0, TIMEOUT + 3);
      run_race(en, f, $urandom_range(0, 2));
    end

    // T5: async reset mid-race with a winner already recorded
    lane_en = 4'hF; ready = 4'hF; done = '0;
    step();
    done = 4'h1;
    step();
    check("t5_pre_start", start, 4'hE);
    check("t5_pre_wv", winner_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t5_start", start, 4'h0);
    check("t5_wv", winner_valid, 1'b0);
    check("t5_timeout", timeout, 1'b0);
    check("t5_active", race_active, 1'b0);
    do_reset();

    // T6: done already high on an enabled lane in IDLE
    lane_en = 4'hF; ready = 4'hF; done = 4'h1;
    step();
`ifdef FALSE_START_DET_EN
    check("t6_start", start, 4'h0);
    check("t6_active", race_active, 1'b0);
    check("t6_false_start", false_start, 1'b1);
    done = 4'h0;
    step();
    check("t6_go_start", start, 4'hF);
    check("t6_go_false_start", false_start, 1'b0);
`else
    check("t6_start", start, 4'hF);
    check("t6_active", race_active, 1'b1);
    check("t6_false_start", false_start, 1'b0);
`endif
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
